countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//   Down-counting hh:mm:ss timer; the count-down counterpart of the elapsed-time counter.
//   Host loads a preset, starts/pauses it; block decrements once per second-tick, borrows
//   across sec/min/hr, flags expiry at 00:00:00. Feeds the same display/alarm path.
// PARAMETERS
//   SECOND_REF  250  clock cycles per second (sim value; board value set at top level), >=2
//   MAX_HOURS   99   largest legal hours preset
// PORTS
//   clock        in   1  single system clock, all logic on posedge
//   reset        in   1  synchronous, active-high; dominates every other input
//   load         in   1  capture set_* (ignored while RUNNING)
//   set_seconds  in   8  preset seconds, binary, legal 0..59
//   set_minutes  in   8  preset minutes, binary, legal 0..59
//   set_hours    in   8  preset hours, binary, legal 0..MAX_HOURS
//   start        in   1  begin/resume counting
//   pause        in   1  freeze counting, keep partial second
//   seconds      out  8  remaining seconds (registered)
//   minutes      out  8  remaining minutes (registered)
//   hours        out  8  remaining hours (registered)
//   running      out  1  high while state==RUNNING
//   expired      out  1  level, high in EXPIRED until next valid load or reset
//   done         out  1  one-cycle pulse on entry to EXPIRED
//   load_err     out  1  one-cycle pulse when a load is rejected (out-of-range preset)
// BEHAVIOUR
//   Reset: seconds/minutes/hours=0, running=expired=done=load_err=0, prescaler=0, state IDLE.
//   States: IDLE, RUNNING, PAUSED, EXPIRED. Priority same cycle: reset > load > pause > start.
//   IDLE:    valid load -> IDLE (new value, prescaler=0); start -> RUNNING if value!=0,
//            else -> EXPIRED (done pulse).
//   RUNNING: pause -> PAUSED; load/start ignored (no load_err); tick that makes value
//            00:00:00 -> EXPIRED, done=1 in the cycle outputs first show 00:00:00.
//   PAUSED:  start -> RUNNING (prescaler resumes from held count); valid load -> IDLE.
//   EXPIRED: outputs hold 0; start/pause ignored; valid load -> IDLE, expired drops.
//   Load check: any set_* out of range -> load_err pulse next cycle; values/state unchanged.
//   Prescaler: counts only in RUNNING, width $clog2(SECOND_REF); tick when count==SECOND_REF-1,
//     count wraps to 0 that cycle. First decrement visible SECOND_REF cycles after the first
//     RUNNING cycle. Pause holds count; load and reset clear it.
//   Decrement per tick: sec>0 -> sec-1; else min>0 -> sec=59,min-1;
//     else hr>0 -> sec=59,min=59,hr-1. Never underflows; no wrap past 00:00:00.
//   Reset mid-run: next cycle all zero, IDLE, no done pulse.
// STRUCTURE
//   Package timer_pkg: state encoding, SEC_MAX=59, MIN_MAX=59, default MAX_HOURS, field width 8.
//   Sub-module second_prescaler (clock, reset, enable, clear -> tick); shared with the
//   elapsed-time counter. FSM, borrow chain, load check stay in this module.
// TESTING (SECOND_REF=4 unless noted)
//   1 reset for 2 cycles -> all outputs 0, running=0, no done/load_err pulse.
//   2 load 00:01:05, start -> 00:01:01 after 4 ticks, 00:00:59 after 6, done single
//     pulse + expired at tick 65, outputs stay 00:00:00.
//   3 load 01:00:00, start, one tick -> 00:59:59; load 00:00:00, start -> done next cycle.
//   4 pause after 2 RUNNING cycles, hold 10 cycles, start -> next decrement 2 RUNNING cycles later.
//   5 load 00:60:00 -> load_err pulse, values unchanged; load 00:00:10 while RUNNING -> ignored.
//   6 reset mid-run at 00:00:30 -> zeros, IDLE next cycle; load+start same cycle -> load wins.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the hh:mm:ss timers.
// Holds the state encoding and the one-second borrow helper.
package timer_pkg;
  localparam int W = 8;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int MAX_HOURS_DEF = 99;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXP
  } state_t;

  typedef struct packed {
    logic [W-1:0] hr;
    logic [W-1:0] min;
    logic [W-1:0] sec;
  } hms_t;

  // Borrow one second; a zero value stays zero.
  function automatic hms_t hms_dec(hms_t t);
    hms_t r;
    r = t;
    if (t.sec != '0) begin
      r.sec = t.sec - 1'b1;
    end else if (t.min != '0) begin
      r.sec = W'(SEC_MAX);
      r.min = t.min - 1'b1;
    end else if (t.hr != '0) begin
      r.sec = W'(SEC_MAX);
      r.min = W'(MIN_MAX);
      r.hr  = t.hr - 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/countdown_timer_if.sv
// Host-side bundle of the countdown timer.
// master = host, slave = timer.
interface countdown_timer_if;
  import timer_pkg::*;
  logic         load;
  logic [W-1:0] set_seconds;
  logic [W-1:0] set_minutes;
  logic [W-1:0] set_hours;
  logic         start;
  logic         pause;
  logic [W-1:0] seconds;
  logic [W-1:0] minutes;
  logic [W-1:0] hours;
  logic         running;
  logic         expired;
  logic         done;
  logic         load_err;

  modport master (
    output load, set_seconds, set_minutes, set_hours,
    output start, pause,
    input  seconds, minutes, hours,
    input  running, expired, done, load_err
  );

  modport slave (
    input  load, set_seconds, set_minutes, set_hours,
    input  start, pause,
    output seconds, minutes, hours,
    output running, expired, done, load_err
  );
endinterface

// File: rtl/countdown_timer_second_prescaler.sv
// Divides the system clock down to a one-per-second tick.
// The partial count is held while enable is low.
module second_prescaler #(
  parameter int SECOND_REF = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic tick
);
  localparam int CW = (SECOND_REF > 1) ? $clog2(SECOND_REF) : 1;
  localparam logic [CW-1:0] LAST = CW'(SECOND_REF - 1);

  logic [CW-1:0] r_cnt;
  logic          w_last;

  assign w_last = (r_cnt == LAST);
  assign tick   = enable && w_last;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/countdown_timer.sv
// Down-counting hh:mm:ss timer with load/start/pause control.
// Flags expiry at 00:00:00 and rejects out-of-range presets.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int SECOND_REF = 250,
  parameter int MAX_HOURS  = MAX_HOURS_DEF
) (
  input  logic              clock,
  input  logic              reset,
  countdown_timer_if.slave  bus
);
  state_t r_state, w_next;
  hms_t   r_val, w_dec, w_set;
  logic   r_done, r_load_err;
  logic   w_tick, w_run_en, w_zero, w_dec_zero;
  logic   w_load_ok, w_load_act, w_load_take, w_load_bad;
  logic   w_running, w_expired, w_go;

  assign w_set = {bus.set_hours, bus.set_minutes, bus.set_seconds};
  assign w_load_ok = (bus.set_seconds <= W'(SEC_MAX))
                  && (bus.set_minutes <= W'(MIN_MAX))
                  && (bus.set_hours   <= W'(MAX_HOURS));
  // A load while running is dropped silently, never flagged.
  assign w_load_act  = bus.load && (r_state != S_RUN);
  assign w_load_take = w_load_act && w_load_ok;
  assign w_load_bad  = w_load_act && !w_load_ok;
  assign w_go        = !w_load_act && !bus.pause && bus.start;

  assign w_run_en   = (r_state == S_RUN) && !bus.pause;
  assign w_dec      = hms_dec(r_val);
  assign w_zero     = (r_val == '0);
  assign w_dec_zero = (w_dec == '0);

  second_prescaler #(
    .SECOND_REF (SECOND_REF)
  ) u_presc (
    .clock  (clock),
    .reset  (reset),
    .enable (w_run_en),
    .clear  (w_load_take),
    .tick   (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) w_next = w_zero ? S_EXP : S_RUN;
      end
      S_RUN: begin
        if (bus.pause)                w_next = S_PAUSE;
        else if (w_tick && w_dec_zero) w_next = S_EXP;
      end
      S_PAUSE: begin
        if (w_load_take) w_next = S_IDLE;
        else if (w_go)   w_next = S_RUN;
      end
      S_EXP: begin
        if (w_load_take) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_running = (r_state == S_RUN);
    w_expired = (r_state == S_EXP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_val      <= '0;
      r_done     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_done     <= (w_next == S_EXP) && (r_state != S_EXP);
      r_load_err <= w_load_bad;
      if (w_load_take)  r_val <= w_set;
      else if (w_tick)  r_val <= w_dec;
    end
  end

  assign bus.seconds  = r_val.sec;
  assign bus.minutes  = r_val.min;
  assign bus.hours    = r_val.hr;
  assign bus.running  = w_running;
  assign bus.expired  = w_expired;
  assign bus.done     = r_done;
  assign bus.load_err = r_load_err;
endmodule
